// File: rtl/float_norm_round_pkg.sv
// float_norm_round_pkg: shared float field widths, limits, state encoding and packed-result offsets.
package float_norm_round_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int INT_W    = 3;
  localparam int GRS_W    = 3;
  localparam int MANT_W   = INT_W + FRAC_W + GRS_W;
  localparam int BIAS     = 2 ** (EXP_W - 1) - 1;
  localparam int EXP_MAX  = 2 ** EXP_W - 1;
  localparam int RES_W    = 1 + EXP_W + FRAC_W;
  localparam int SIGN_POS = EXP_W + FRAC_W;
  localparam int EXP_LSB  = FRAC_W;
  localparam int FRAC_LSB = 0;
  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND} fnr_state_t;
endpackage

// File: rtl/fnr_round_pack.sv
// fnr_round_pack: round-to-nearest-even on a normalized/denormal mantissa, renormalize and pack.
module fnr_round_pack
  import float_norm_round_pkg::*;
#(
  parameter int EXP_W  = float_norm_round_pkg::EXP_W,
  parameter int FRAC_W = float_norm_round_pkg::FRAC_W,
  parameter int GRS_W  = float_norm_round_pkg::GRS_W
) (
  input  logic                      i_sign,
  input  logic [FRAC_W+GRS_W:0]     i_mant,
  input  logic signed [EXP_W+1:0]   i_exp,
  output logic [EXP_W+FRAC_W:0]     o_result,
  output logic                      o_overflow,
  output logic                      o_underflow
);
  localparam logic signed [EXP_W+1:0] EXP_TOP = (EXP_W + 2)'(2 ** EXP_W - 1);
  logic                    w_up;
  logic [FRAC_W+1:0]       w_sum;
  logic [FRAC_W:0]         w_sig;
  logic signed [EXP_W+1:0] w_exp;
  logic                    w_norm;
  always_comb begin
    w_up        = i_mant[GRS_W-1] & (i_mant[GRS_W-2] | (|i_mant[GRS_W-3:0]) | i_mant[GRS_W]);
    w_sum       = {1'b0, i_mant[FRAC_W+GRS_W:GRS_W]} + (FRAC_W + 2)'(w_up);
    w_sig       = w_sum[FRAC_W+1] ? w_sum[FRAC_W+1:1] : w_sum[FRAC_W:0];
    w_exp       = i_exp + (EXP_W + 2)'(w_sum[FRAC_W+1]);
    w_norm      = w_sig[FRAC_W];
    o_overflow  = w_exp >= EXP_TOP;
    o_underflow = !o_overflow && !w_norm && (|i_mant);
    o_result    = o_overflow ? {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                : {i_sign, w_norm ? w_exp[EXP_W-1:0] : {EXP_W{1'b0}}, w_sig[FRAC_W-1:0]};
  end
endmodule

// File: rtl/float_norm_round.sv
// float_norm_round: iterative normalize (one shift per cycle), round-to-nearest-even and IEEE-754 pack.
module float_norm_round
  import float_norm_round_pkg::*;
#(
  parameter int EXP_W  = float_norm_round_pkg::EXP_W,
  parameter int FRAC_W = float_norm_round_pkg::FRAC_W,
  parameter int INT_W  = float_norm_round_pkg::INT_W,
  parameter int GRS_W  = float_norm_round_pkg::GRS_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          sign_in,
  input  logic [EXP_W-1:0]              exp_in,
  input  logic [INT_W+FRAC_W+GRS_W-1:0] mant_in,
  output logic [EXP_W+FRAC_W:0]         result,
  output logic                          done,
  output logic                          busy,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int MW = INT_W + FRAC_W + GRS_W;
  localparam int NB = FRAC_W + GRS_W;
  localparam int XW = EXP_W + 2;
  fnr_state_t           r_state, w_state_nxt;
  logic                 r_sign;
  logic [MW-1:0]        r_mant, w_mant_nxt;
  logic signed [XW-1:0] r_exp, w_exp_nxt;
  logic [EXP_W+FRAC_W:0] r_result, w_result;
  logic                 r_done, r_ovf, r_unf;
  logic                 w_ovf, w_unf, w_hi;
  assign w_hi = |r_mant[MW-1:NB+1];
  always_comb begin
    w_state_nxt = r_state;
    w_mant_nxt  = r_mant;
    w_exp_nxt   = r_exp;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_NORM;
        w_mant_nxt  = mant_in;
        w_exp_nxt   = (exp_in == '0) ? XW'(1) : XW'(exp_in);
      end
      S_NORM: if (r_mant == '0) begin
        w_state_nxt = S_ROUND;
      end else if (w_hi) begin
        // the bit dropped on a right shift folds into sticky
        w_mant_nxt = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
        w_exp_nxt  = r_exp + XW'(1);
      end else if (!r_mant[NB] && r_exp > XW'(1)) begin
        w_mant_nxt = {r_mant[MW-2:0], 1'b0};
        w_exp_nxt  = r_exp - XW'(1);
      end else begin
        w_state_nxt = S_ROUND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mant  <= w_mant_nxt;
      r_exp   <= w_exp_nxt;
      r_done  <= r_state == S_ROUND;
      if (r_state == S_IDLE && start) begin
        r_sign <= sign_in;
        r_ovf  <= 1'b0;
        r_unf  <= 1'b0;
      end
      if (r_state == S_ROUND) begin
        r_result <= w_result;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
      end
    end
  end
  fnr_round_pack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .GRS_W(GRS_W)) u_round_pack (
    .i_sign     (r_sign),
    .i_mant     (r_mant[NB:0]),
    .i_exp      (r_exp),
    .o_result   (w_result),
    .o_overflow (w_ovf),
    .o_underflow(w_unf)
  );
  assign result    = r_result;
  assign done      = r_done;
  assign busy      = r_state != S_IDLE;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: doc/float_norm_round.md
Name: float_norm_round

Overview:
Downstream stage of the floating-point ULA. It takes the ULA's unnormalized 29-bit magnitude result (c, sign_c) together with the biased exponent of that result. It normalizes the magnitude iteratively (one shift per cycle), rounds to nearest-even using the guard/round/sticky bits, and packs an IEEE-754 single-precision word. It is started by the ULA's done pulse and produces its own one-cycle done pulse.

Parameters:
EXP_W, 8, exponent field width; exponent bias is 2^(EXP_W-1)-1
FRAC_W, 23, stored fraction width
INT_W, 3, integer bits above the binary point in mant_in
GRS_W, 3, guard/round/sticky bits below the fraction in mant_in

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  sampled only in IDLE; high there launches an operation
sign_in  input  1  result sign (ULA sign_c)
exp_in  input  EXP_W  biased exponent of mant_in; the weight of bit FRAC_W+GRS_W is 2^(exp_in-bias)
mant_in  input  INT_W+FRAC_W+GRS_W (29)  ULA magnitude c: [28:26] integer bits, [25:3] fraction, [2] guard, [1] round, [0] sticky
result  output  1+EXP_W+FRAC_W (32)  packed {sign, exponent, fraction}
done  output  1  one-cycle pulse; result valid from this cycle
busy  output  1  high in every state except IDLE
overflow  output  1  set with done when the result saturates to infinity
underflow  output  1  set with done when the result is denormal or rounds to zero from nonzero

Behaviour:
- Reset: state IDLE; result=0, done=0, busy=0, overflow=0, underflow=0; internal registers cleared. Reset has priority in every state, including mid-operation. An aborted operation produces no done pulse.
- States: IDLE, NORM, ROUND.
- IDLE:
  - If start=1, register sign_in, mant_in and exp_in into a 10-bit signed working exponent. exp_in=0 is treated as 1.
  - Go to NORM. Clear overflow and underflow.
  - result holds its last value.
- NORM (one action per cycle, in priority order):
  - Mantissa is zero: go to ROUND.
  - Any bit above bit 26 is set: shift right by 1, OR the shifted-out bit into sticky bit 0, exponent+1.
  - Bit 26 = 0 and exponent > 1: shift left by 1 (zero fill), exponent-1.
  - Otherwise (normalized, or exponent==1 denormal): go to ROUND.
- ROUND (single cycle, combinational inside):
  - round_up = G & (R | S | LSB), where LSB is bit 3.
  - Add round_up at bit 3. If the carry makes bit 27 set, shift right by 1 and exponent+1.
  - Exponent >= 255: result = {sign, 8'hFF, 0}, overflow=1.
  - Bit 26 = 0 after rounding: exponent field 0 (denormal, or zero). underflow=1 if the mantissa was nonzero. A zero mantissa gives signed zero.
  - Otherwise: exponent field = exponent[7:0], fraction = bits [25:3].
  - Register result, pulse done=1, return to IDLE.
- Latency, counted in edges from the edge that samples start to the edge that raises done: 3 plus one per NORM shift. An already-normalized input therefore takes 3.
- start while busy: ignored. start held high in IDLE relaunches on every return to IDLE, so it may be tied directly to the ULA done pulse.
- done is high exactly one cycle. overflow and underflow stay valid until the next launch.
- Left shifts cannot exceed 26, because zero is caught first, so the working exponent never goes below 1.

Decomposition:
- Shared float package holds:
  - the field-width constants EXP_W, FRAC_W, INT_W, GRS_W
  - BIAS
  - EXP_MAX (255)
  - the state encoding
  - the packed-result field offsets
  These are reused by the ULA and by the upstream unpack stage.
- One natural sub-module: fnr_round_pack. It is combinational: rounding, post-round renormalize, exponent overflow/denormal selection and packing. It is instantiated in ROUND.

Test Plan:
1. mant_in={001,23'h0,000}, exp_in=127, sign_in=0 -> result 0x3F800000, done after 3 edges, overflow=underflow=0.
2. mant_in={011,1,22'h0,000} (3.5), exp_in=127 -> one right shift, result 0x40600000, done after 4 edges. Same mant_in with exp_in=254 -> 0x7F800000, overflow=1.
3. mant_in={000,001,20'h0,000} (0.125), exp_in=127, sign_in=1 -> 3 left shifts, result 0xBE000000, done after 6 edges.
4. Rounding, both with exp_in=127:
   - mant_in={001,23'h7FFFFF,100} -> tie with odd LSB, rounds up to 2.0, result 0x40000000.
   - mant_in={001,23'h0,100} -> tie with even LSB, result 0x3F800000.
5. Zero and denormal:
   - mant_in=0, sign_in=1 -> 0x80000000 after 3 edges, underflow=0.
   - mant_in={000,010,20'h0,000}, exp_in=1 -> no shift, result 0x00200000, underflow=1.
6. Reset mid-operation: launch case 3, assert reset for one cycle at the second NORM cycle -> next edge busy=0, result=0, no done pulse. A fresh launch of case 1 then gives 0x3F800000.
